// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM reader that fetches the system ID and build timestamp
// from the sysid slave, checks the ID against EXPECTED_ID and publishes the result
// together with saturating check/fail counters. Runs once after reset when AUTO_START
// is set and again on every start pulse accepted in IDLE.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter int          READ_LATENCY = 0,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic        id_ok,
  output logic [31:0] id_value,
  output logic [31:0] timestamp,
  output logic [7:0]  check_count,
  output logic [7:0]  fail_count
);

  typedef enum logic [2:0] {IDLE, RD_ID, WT_ID, RD_TS, WT_TS, DONE} state_t;

  // Latency is 0..3, so two bits hold it; 0 means the data is valid in the read cycle.
  localparam logic [1:0] LAT = READ_LATENCY[1:0];

  state_t      state;
  logic [1:0]  wait_cnt;
  logic        auto_pending;
  logic [31:0] id_shadow;
  logic [31:0] ts_shadow;
  logic        last_wait;
  logic        capture_id;
  logic        capture_ts;
  logic        pass;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The final wait cycle is the one in which the slave presents the read data.
  assign last_wait  = (wait_cnt == LAT - 2'd1);
  assign capture_id = ((state == RD_ID) && (LAT == 2'd0)) || ((state == WT_ID) && last_wait);
  assign capture_ts = ((state == RD_TS) && (LAT == 2'd0)) || ((state == WT_TS) && last_wait);
  assign pass       = (id_shadow == EXPECTED_ID) && (ts_shadow != 32'd0);

  // Shadow registers hold the words of the check in flight; published outputs stay untouched until DONE.
  always_ff @(posedge clock) begin
    if (capture_id) id_shadow <= m_readdata;
    if (capture_ts) ts_shadow <= m_readdata;
  end

  // Sequencer with registered bus strobes, status and published results.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      wait_cnt     <= 2'd0;
      auto_pending <= AUTO_START;
      m_read       <= 1'b0;
      m_address    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      valid        <= 1'b0;
      id_ok        <= 1'b0;
      id_value     <= 32'd0;
      timestamp    <= 32'd0;
      check_count  <= 8'd0;
      fail_count   <= 8'd0;
    end else begin
      m_read <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          // The auto-start flag is consumed by the first IDLE cycle after reset.
          auto_pending <= 1'b0;
          if (start || auto_pending) begin
            state     <= RD_ID;
            m_read    <= 1'b1;
            m_address <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RD_ID: begin
          wait_cnt <= 2'd0;
          if (LAT == 2'd0) begin
            state     <= RD_TS;
            m_read    <= 1'b1;
            m_address <= 1'b1;
          end else begin
            state <= WT_ID;
          end
        end
        WT_ID: begin
          if (last_wait) begin
            state     <= RD_TS;
            m_read    <= 1'b1;
            m_address <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        RD_TS: begin
          wait_cnt <= 2'd0;
          if (LAT == 2'd0) begin
            state     <= DONE;
            done      <= 1'b1;
            m_address <= 1'b0;
          end else begin
            state <= WT_TS;
          end
        end
        WT_TS: begin
          if (last_wait) begin
            state     <= DONE;
            done      <= 1'b1;
            m_address <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        DONE: begin
          state       <= IDLE;
          busy        <= 1'b0;
          id_value    <= id_shadow;
          timestamp   <= ts_shadow;
          id_ok       <= pass;
          valid       <= 1'b1;
          check_count <= sat_inc(check_count);
          if (!pass) fail_count <= sat_inc(fail_count);
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          m_address <= 1'b0;
        end
      endcase
    end
  end

endmodule
